// File: rtl/sort4_ctrl_pkg.sv
// Shared types and constants for the four-element bubble-sort controller.
package sort4_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned N_ELEM = 4;
   localparam int unsigned CNT_W  = 3;

endpackage

// File: rtl/sort4_ctrl_cmp.sv
// Unsigned W-bit less-than comparator shared by every SCAN step.
module cmp_lt4 #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         lt
);

   assign lt = (a < b);

endmodule

// File: rtl/sort4_ctrl.sv
// Four-element in-place bubble sorter, one compare per SCAN cycle.
// Optional swap counter enabled by defining SORT4_SWAPCNT_EN.
module sort4_ctrl
   import sort4_ctrl_pkg::*;
#(
   parameter int unsigned W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [N_ELEM*W-1:0]  din,
   output logic                 busy,
   output logic                 done,
   output logic [N_ELEM*W-1:0]  dout,
   output logic [CNT_W-1:0]     swap_cnt
);

   state_t       state, state_n;
   logic [W-1:0] e   [N_ELEM];
   logic [W-1:0] e_n [N_ELEM];
   logic [1:0]   idx, idx_n, idx_p1;
   logic [1:0]   last, last_n;
   logic         swapped, swapped_n;
   logic         pass_swapped;
   logic         lt;

   assign idx_p1 = idx + 2'd1;

   cmp_lt4 #(.W(W)) u_cmp (
      .a  (e[idx_p1]),
      .b  (e[idx]),
      .lt (lt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         for (int unsigned k = 0; k < N_ELEM; k++) e[k] <= '0;
         idx     <= 2'd0;
         last    <= 2'd2;
         swapped <= 1'b0;
      end else begin
         state   <= state_n;
         e       <= e_n;
         idx     <= idx_n;
         last    <= last_n;
         swapped <= swapped_n;
      end
   end

   always_comb begin
      state_n      = state;
      e_n          = e;
      idx_n        = idx;
      last_n       = last;
      swapped_n    = swapped;
      pass_swapped = swapped | lt;
      case (state)
         IDLE: begin
            if (start) begin
               for (int unsigned k = 0; k < N_ELEM; k++) e_n[k] = din[k*W +: W];
               idx_n     = 2'd0;
               last_n    = 2'd2;
               swapped_n = 1'b0;
               state_n   = SCAN;
            end
         end
         SCAN: begin
            if (lt) begin
               e_n[idx]    = e[idx_p1];
               e_n[idx_p1] = e[idx];
            end
            // End of a pass: stop early once a full pass made no swap.
            if (idx < last) begin
               idx_n     = idx_p1;
               swapped_n = pass_swapped;
            end else if ((last == 2'd0) || !pass_swapped) begin
               swapped_n = pass_swapped;
               state_n   = DONE;
            end else begin
               idx_n     = 2'd0;
               last_n    = last - 2'd1;
               swapped_n = 1'b0;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state == SCAN) || (state == DONE);
   assign done = (state == DONE);

   always_comb begin
      dout = '0;
      for (int unsigned k = 0; k < N_ELEM; k++) dout[k*W +: W] = e[k];
   end

`ifdef SORT4_SWAPCNT_EN
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if ((state == IDLE) && start)
         cnt <= '0;
      else if ((state == SCAN) && lt)
         cnt <= cnt + CNT_W'(1);
   end

   assign swap_cnt = cnt;
`else
   assign swap_cnt = '0;
`endif

endmodule

// File: doc/sort4_ctrl.md
SORT4_CTRL -- requirements
Module: sort4_ctrl

Interface
REQ-001 SHALL have parameter W, default 4, element width in bits (unsigned).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to load din and sort; sampled only in IDLE.
REQ-005 SHALL have port din  input  4*W  four elements; element k at bits [k*W +: W].
REQ-006 SHALL have port busy  output  1  high in SCAN and DONE states.
REQ-007 SHALL have port done  output  1  one-cycle pulse when dout holds the sorted result.
REQ-008 SHALL have port dout  output  4*W  element registers; element 0 is smallest after done.
REQ-009 SHALL have port swap_cnt  output  3  number of swaps performed in the current/last sort.

Function
REQ-010 SHALL implement FSM states IDLE, SCAN, DONE; one shared less-than comparator; one compare per SCAN cycle.
REQ-011 IDLE with start=1 SHALL load din into element regs, clear swap_cnt, set idx=0, last=2, swapped=0, go to SCAN.
REQ-012 SCAN SHALL compare e[idx+1] < e[idx] (unsigned); if true, swap both elements, set swapped, increment swap_cnt.
REQ-013 Equal elements SHALL NOT be swapped.
REQ-014 SCAN with idx<last SHALL increment idx.
REQ-015 SCAN with idx==last SHALL go to DONE if last==0 or no swap occurred in the pass (including this cycle); else idx=0, last=last-1, swapped=0.
REQ-016 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-017 start while busy SHALL be ignored, with no effect on state or outputs.
REQ-018 dout and swap_cnt SHALL hold their values in IDLE until the next accepted start.
REQ-019 Latency, measured from the accepted-start edge: sorted input = 3 SCAN cycles; worst case = 6 SCAN cycles; done follows in the next cycle.
REQ-020 swap_cnt SHALL never exceed 6.

Reset
REQ-021 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, dout=0, swap_cnt=0, idx=0, last=2, swapped=0.
REQ-022 Reset mid-SCAN SHALL abort the sort without a done pulse; rst SHALL dominate start in the same cycle.

Configuration
REQ-023 Macro SORT4_SWAPCNT_EN defined: swap_cnt counter implemented per REQ-012/REQ-018.
REQ-024 Macro SORT4_SWAPCNT_EN undefined: counter removed, swap_cnt tied to 0; all other behaviour identical.

Structure
REQ-025 A shared package SHALL hold the state enum type (IDLE/SCAN/DONE), the element-count constant 4, and the swap-counter width constant 3.
REQ-026 The comparator SHALL be a sub-module cmp_lt4 (W-bit unsigned a<b, combinational), instantiated once.

Verification
REQ-027 Reversed input: din={15,10,5,0} (e0..e3), start -> dout={0,5,10,15}; 6 SCAN cycles; done on 7th cycle after start; swap_cnt=6.
REQ-028 Sorted input: din={1,2,3,4} -> dout unchanged; 3 SCAN cycles; done on 4th cycle; swap_cnt=0.
REQ-029 Duplicates: din={7,7,3,7} -> dout={3,7,7,7}; swap_cnt=2; no swaps between equal elements.
REQ-030 Start while busy: din={2,1,0,3} accepted, second start with {9,9,9,9} two cycles later -> result {0,1,2,3}; second start ignored.
REQ-031 Reset mid-sort: rst during 3rd SCAN cycle -> next cycle IDLE, dout=0, swap_cnt=0, no done pulse; a new sort of {4,3,2,1} completes to {1,2,3,4}.
REQ-032 Build without SORT4_SWAPCNT_EN: rerun REQ-027 -> same dout and timing; swap_cnt=0 throughout.
